// File: rtl/mips_exec_unit.sv
// Execute stage of the single-cycle MIPS core: ALU/multiply/divide datapath plus
// next-PC selection with a one-instruction branch/jump delay slot.
module mips_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic        branch,
  input  logic        condition_met,
  input  logic        jump1,
  input  logic        jump2,
  output logic [4:0]  alu_ctrl,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] tgt_addr_0,
  output logic [31:0] tgt_addr_1,
  output logic        redirect,
  output logic [31:0] pcin
);

  localparam logic [4:0] OP_ADDU  = 5'd0;
  localparam logic [4:0] OP_SUBU  = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLT   = 5'd5;
  localparam logic [4:0] OP_SLTU  = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_SLLV  = 5'd10;
  localparam logic [4:0] OP_SRLV  = 5'd11;
  localparam logic [4:0] OP_SRAV  = 5'd12;
  localparam logic [4:0] OP_LUI   = 5'd13;
  localparam logic [4:0] OP_MULT  = 5'd14;
  localparam logic [4:0] OP_MULTU = 5'd15;
  localparam logic [4:0] OP_DIV   = 5'd16;
  localparam logic [4:0] OP_DIVU  = 5'd17;

  always_comb begin
    alu_ctrl = OP_ADDU;
    case (alu_op)
      2'b01: alu_ctrl = OP_SUBU;
      2'b10: begin
        case (funct)
          6'b000000: alu_ctrl = OP_SLL;
          6'b000010: alu_ctrl = OP_SRL;
          6'b000011: alu_ctrl = OP_SRA;
          6'b000100: alu_ctrl = OP_SLLV;
          6'b000110: alu_ctrl = OP_SRLV;
          6'b000111: alu_ctrl = OP_SRAV;
          6'b011000: alu_ctrl = OP_MULT;
          6'b011001: alu_ctrl = OP_MULTU;
          6'b011010: alu_ctrl = OP_DIV;
          6'b011011: alu_ctrl = OP_DIVU;
          6'b100011: alu_ctrl = OP_SUBU;
          6'b100100: alu_ctrl = OP_AND;
          6'b100101: alu_ctrl = OP_OR;
          6'b100110: alu_ctrl = OP_XOR;
          6'b101010: alu_ctrl = OP_SLT;
          6'b101011: alu_ctrl = OP_SLTU;
          default:   alu_ctrl = OP_ADDU;
        endcase
      end
      2'b11: begin
        case (opcode)
          6'b001010: alu_ctrl = OP_SLT;
          6'b001011: alu_ctrl = OP_SLTU;
          6'b001100: alu_ctrl = OP_AND;
          6'b001101: alu_ctrl = OP_OR;
          6'b001110: alu_ctrl = OP_XOR;
          6'b001111: alu_ctrl = OP_LUI;
          default:   alu_ctrl = OP_ADDU;
        endcase
      end
      default: alu_ctrl = OP_ADDU;
    endcase
  end

  // One shared multiplier and one shared unsigned divider; signed forms
  // sign-extend (multiply) or divide magnitudes and fix signs afterwards.
  logic        md_signed;
  logic [4:0]  sh_amt;
  logic [63:0] prod;
  logic [31:0] dvd, dvs, q_mag, r_mag, quot, rem;

  always_comb begin
    md_signed = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
    sh_amt    = (alu_ctrl == OP_SLLV || alu_ctrl == OP_SRLV || alu_ctrl == OP_SRAV)
                ? a[4:0] : shamt;
    prod      = {{32{md_signed & a[31]}}, a} * {{32{md_signed & b[31]}}, b};
    dvd       = (md_signed && a[31]) ? -a : a;
    dvs       = (md_signed && b[31]) ? -b : b;
    q_mag     = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    r_mag     = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
    quot      = (md_signed && (a[31] ^ b[31])) ? -q_mag : q_mag;
    rem       = (md_signed && a[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    alu_out = 32'd0;
    hi      = 32'd0;
    lo      = 32'd0;
    case (alu_ctrl)
      OP_ADDU:  alu_out = a + b;
      OP_SUBU:  alu_out = a - b;
      OP_AND:   alu_out = a & b;
      OP_OR:    alu_out = a | b;
      OP_XOR:   alu_out = a ^ b;
      OP_SLT:   alu_out = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:  alu_out = {31'd0, a < b};
      OP_SLL, OP_SLLV: alu_out = b << sh_amt;
      OP_SRL, OP_SRLV: alu_out = b >> sh_amt;
      OP_SRA, OP_SRAV: alu_out = $unsigned($signed(b) >>> sh_amt);
      OP_LUI:   alu_out = {b[15:0], 16'd0};
      OP_MULT, OP_MULTU: {hi, lo} = prod;
      OP_DIV, OP_DIVU: begin
        hi = rem;
        lo = quot;
      end
      default:  alu_out = a + b;
    endcase
  end

  assign zero = (alu_out == 32'd0);

  logic take;
  assign take = jump1 | jump2 | (branch & condition_met);

  always_comb begin
    if (jump2)                      tgt_addr_0 = a;
    else if (jump1)                 tgt_addr_0 = jump_addr;
    else if (branch & condition_met) tgt_addr_0 = branch_addr;
    else                            tgt_addr_0 = pc_plus4;
  end

  // The redirect is registered so the delay-slot instruction still fetches pc_plus4.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tgt_addr_1 <= 32'd0;
      redirect   <= 1'b0;
    end else if (clk_enable) begin
      tgt_addr_1 <= tgt_addr_0;
      redirect   <= take;
    end
  end

  assign pcin = redirect ? tgt_addr_1 : pc_plus4;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Scoreboarded bench for mips_exec_unit: directed test-plan cases plus random
// stimulus checked against a behavioural model of the execute stage.
module tb_mips_exec_unit;

  typedef struct packed {
    logic        rst_n;
    logic        en;
    logic [1:0]  alu_op;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc_plus4;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic        branch;
    logic        cond;
    logic        j1;
    logic        j2;
  } stim_t;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] out;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] tgt0;
    logic [31:0] tgt1;
    logic        redirect;
    logic [31:0] pcin;
  } resp_t;

  localparam int W = $bits(resp_t);

  logic        clk, reset, clk_enable, branch, condition_met, jump1, jump2;
  logic [1:0]  alu_op;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] a, b, pc_plus4, branch_addr, jump_addr;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_out, hi, lo, tgt_addr_0, tgt_addr_1, pcin;
  logic        zero, redirect;

  mips_exec_unit dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .alu_op(alu_op), .opcode(opcode), .funct(funct), .shamt(shamt),
    .a(a), .b(b), .pc_plus4(pc_plus4), .branch_addr(branch_addr),
    .jump_addr(jump_addr), .branch(branch), .condition_met(condition_met),
    .jump1(jump1), .jump2(jump2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .zero(zero), .hi(hi), .lo(lo), .tgt_addr_0(tgt_addr_0),
    .tgt_addr_1(tgt_addr_1), .redirect(redirect), .pcin(pcin)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  stim_t cur;
  logic        m_redirect;
  logic [31:0] m_tgt;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // Reference model
  function automatic int ref_op(stim_t s);
    case (s.alu_op)
      2'b00: return 0;
      2'b01: return 1;
      2'b10:
        case (s.funct)
          6'd0:  return 7;
          6'd2:  return 8;
          6'd3:  return 9;
          6'd4:  return 10;
          6'd6:  return 11;
          6'd7:  return 12;
          6'd24: return 14;
          6'd25: return 15;
          6'd26: return 16;
          6'd27: return 17;
          6'd33: return 0;
          6'd35: return 1;
          6'd36: return 2;
          6'd37: return 3;
          6'd38: return 4;
          6'd42: return 5;
          6'd43: return 6;
          default: return 0;
        endcase
      default:
        case (s.opcode)
          6'd9:  return 0;
          6'd10: return 5;
          6'd11: return 6;
          6'd12: return 2;
          6'd13: return 3;
          6'd14: return 4;
          6'd15: return 13;
          default: return 0;
        endcase
    endcase
  endfunction

  function automatic logic [31:0] ref_target(stim_t s);
    if (s.j2) return s.a;
    if (s.j1) return s.jump_addr;
    if (s.branch && s.cond) return s.branch_addr;
    return s.pc_plus4;
  endfunction

  function automatic resp_t ref_resp(stim_t s);
    resp_t r;
    int op, ia, ib;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    op = ref_op(s);
    ia = s.a; ib = s.b;
    sa = ia;  sb = ib;
    ua = {32'd0, s.a}; ub = {32'd0, s.b};
    r = '0;
    r.ctrl = 5'(op);
    case (op)
      0:  r.out = s.a + s.b;
      1:  r.out = s.a - s.b;
      2:  r.out = s.a & s.b;
      3:  r.out = s.a | s.b;
      4:  r.out = s.a ^ s.b;
      5:  r.out = (sa < sb) ? 32'd1 : 32'd0;
      6:  r.out = (ua < ub) ? 32'd1 : 32'd0;
      7:  r.out = s.b << s.shamt;
      8:  r.out = s.b >> s.shamt;
      9:  r.out = 32'(ib >>> s.shamt);
      10: r.out = s.b << (s.a % 32);
      11: r.out = s.b >> (s.a % 32);
      12: r.out = 32'(ib >>> (s.a % 32));
      13: r.out = s.b * 32'd65536;
      14: begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
      15: begin p = ua * ub;      r.hi = p[63:32]; r.lo = p[31:0]; end
      16: if (sb != 0) begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
      17: if (ub != 0) begin r.lo = 32'(ua / ub); r.hi = 32'(ua % ub); end
      default: r.out = 32'd0;
    endcase
    r.zero     = (r.out == 32'd0);
    r.tgt0     = ref_target(s);
    r.tgt1     = m_tgt;
    r.redirect = m_redirect;
    r.pcin     = m_redirect ? m_tgt : s.pc_plus4;
    return r;
  endfunction

  // Model of what the clock edge does with the inputs it sees
  function automatic void model_edge(stim_t s);
    if (!s.rst_n) begin
      m_tgt = 32'd0;
      m_redirect = 1'b0;
    end else if (s.en) begin
      m_tgt = ref_target(s);
      m_redirect = s.j1 | s.j2 | (s.branch & s.cond);
    end
  endfunction

  task automatic apply(stim_t s);
    reset = s.rst_n; clk_enable = s.en; alu_op = s.alu_op; opcode = s.opcode;
    funct = s.funct; shamt = s.shamt; a = s.a; b = s.b; pc_plus4 = s.pc_plus4;
    branch_addr = s.branch_addr; jump_addr = s.jump_addr; branch = s.branch;
    condition_met = s.cond; jump1 = s.j1; jump2 = s.j2;
  endtask

  // Driver: one instruction per cycle; expected response queued at issue
  task automatic drive(stim_t s);
    resp_t r;
    @(posedge clk);
    model_edge(cur);
    #1;
    cur = s;
    apply(s);
    r = ref_resp(s);
    exp_q.push_back(W'(r));
  endtask

  // Monitor: the combinational response is valid by the falling edge
  always @(negedge clk) begin
    resp_t r;
    if (exp_q.size() > 0) begin
      r = resp_t'(exp_q.pop_front());
      chk("alu_ctrl", {27'd0, alu_ctrl}, {27'd0, r.ctrl});
      chk("alu_out", alu_out, r.out);
      chk("zero", {31'd0, zero}, {31'd0, r.zero});
      chk("hi", hi, r.hi);
      chk("lo", lo, r.lo);
      chk("tgt_addr_0", tgt_addr_0, r.tgt0);
      chk("tgt_addr_1", tgt_addr_1, r.tgt1);
      chk("redirect", {31'd0, redirect}, {31'd0, r.redirect});
      chk("pcin", pcin, r.pcin);
    end
  end

  function automatic stim_t base(logic [31:0] pc);
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.en = 1'b1;
    s.pc_plus4 = pc;
    s.branch_addr = pc + 32'h40;
    s.jump_addr = 32'h0010_0000;
    return s;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 20));
      1: return 32'd0;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] functs[17] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd24, 6'd25,
                             6'd26, 6'd27, 6'd33, 6'd35, 6'd36, 6'd37, 6'd38,
                             6'd42, 6'd43};
  logic [5:0] opcodes[7] = '{6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15};

  initial begin
    stim_t s;
    int idx;
    m_tgt = 32'd0;
    m_redirect = 1'b0;
    cur = base(32'h0040_0000);
    cur.rst_n = 1'b0;
    apply(cur);

    // Reset
    s = base(32'h0040_0000); s.rst_n = 1'b0;
    drive(s);
    @(negedge clk); #1;
    chk("reset_redirect", {31'd0, redirect}, 32'd0);
    chk("reset_tgt1", tgt_addr_1, 32'd0);
    chk("reset_pcin", pcin, 32'h0040_0000);

    s = base(32'h0040_0004); s.alu_op = 2'b10; s.funct = 6'b100011; s.a = 5; s.b = 7;
    drive(s);
    @(negedge clk); #1;
    chk("subu_ctrl", {27'd0, alu_ctrl}, 32'd1);
    chk("subu_out", alu_out, 32'hFFFF_FFFE);
    chk("subu_zero", {31'd0, zero}, 32'd0);
    s.a = 9; s.b = 9;
    drive(s);
    @(negedge clk); #1;
    chk("subu_zero_eq", {31'd0, zero}, 32'd1);

    s = base(32'h0040_0008); s.alu_op = 2'b11; s.opcode = 6'b001111; s.b = 32'h1234;
    drive(s);
    @(negedge clk); #1;
    chk("lui", alu_out, 32'h1234_0000);
    s.opcode = 6'b001010; s.a = 32'hFFFF_FFFF; s.b = 1;
    drive(s);
    @(negedge clk); #1;
    chk("slti", alu_out, 32'd1);
    s.opcode = 6'b001011;
    drive(s);
    @(negedge clk); #1;
    chk("sltiu", alu_out, 32'd0);

    s = base(32'h0040_000C); s.alu_op = 2'b10; s.funct = 6'b000011; s.shamt = 4;
    s.b = 32'h8000_0000;
    drive(s);
    @(negedge clk); #1;
    chk("sra", alu_out, 32'hF800_0000);
    s.funct = 6'b000110; s.shamt = 0; s.a = 36;
    drive(s);
    @(negedge clk); #1;
    chk("srlv", alu_out, 32'h0800_0000);

    s = base(32'h0040_0010); s.alu_op = 2'b10; s.funct = 6'b011000;
    s.a = 32'hFFFF_FFFE; s.b = 3;
    drive(s);
    @(negedge clk); #1;
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_out", alu_out, 32'd0);
    s.funct = 6'b011010; s.a = 32'hFFFF_FFF9; s.b = 2;
    drive(s);
    @(negedge clk); #1;
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    s.funct = 6'b011011; s.b = 0;
    drive(s);
    @(negedge clk); #1;
    chk("divu0_hi", hi, 32'd0);
    chk("divu0_lo", lo, 32'd0);

    // Jump with delay slot
    s = base(32'h0040_0010); s.j1 = 1'b1; s.jump_addr = 32'hBFC0_0100;
    drive(s);
    drive(base(32'h0040_0014));
    @(negedge clk); #1;
    chk("jump_redirect", {31'd0, redirect}, 32'd1);
    chk("jump_pcin", pcin, 32'hBFC0_0100);
    drive(base(32'h0040_0018));
    @(negedge clk); #1;
    chk("after_jump_pcin", pcin, 32'h0040_0018);

    // Not-taken branch, then a disabled jr
    s = base(32'h0040_0200); s.branch = 1'b1; s.cond = 1'b0;
    drive(s);
    s = base(32'h0040_0204); s.en = 1'b0; s.j2 = 1'b1; s.a = 32'h1234_5678;
    drive(s);
    @(negedge clk); #1;
    chk("ntbranch_redirect", {31'd0, redirect}, 32'd0);
    chk("ntbranch_tgt1", tgt_addr_1, 32'h0040_0200);
    drive(base(32'h0040_0208));
    @(negedge clk); #1;
    chk("hold_redirect", {31'd0, redirect}, 32'd0);
    chk("hold_tgt1", tgt_addr_1, 32'h0040_0200);

    // Random stimulus
    for (int i = 0; i < 400; i++) begin
      s = base({$urandom_range(0, 32'h0FFF_FFFF), 2'b00} + 32'h4);
      s.rst_n = ($urandom_range(0, 49) != 0);
      s.en = ($urandom_range(0, 6) != 0);
      s.alu_op = 2'($urandom_range(0, 3));
      idx = $urandom_range(0, 19);
      s.funct = (idx < 17) ? functs[idx] : 6'($urandom);
      idx = $urandom_range(0, 8);
      s.opcode = (idx < 7) ? opcodes[idx] : 6'($urandom);
      s.shamt = 5'($urandom);
      s.a = rand_word();
      s.b = ($urandom_range(0, 7) == 0) ? s.a : rand_word();
      s.branch_addr = {$urandom, 2'b00};
      s.jump_addr = {$urandom, 2'b00};
      case ($urandom_range(0, 5))
        0: s.j1 = 1'b1;
        1: s.j2 = 1'b1;
        2: begin s.branch = 1'b1; s.cond = 1'($urandom); end
        3: begin s.j1 = 1'($urandom); s.j2 = 1'($urandom);
                 s.branch = 1'($urandom); s.cond = 1'($urandom); end
        default: ;
      endcase
      drive(s);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
